fx2_fifo_responder: RTL and testbench
=====================================

FX2_FIFO_RESPONDER -- requirements
Module: fx2_fifo_responder

Interface
REQ-001 The parameters SHALL be: DEPTH, 16, entries per endpoint FIFO (power of 2, >=2); AW, log2(DEPTH), pointer width.
REQ-002 The ports SHALL be: clk  in  1  single clock; all FX2 and host-side signals are synchronous to rising edge (bench ties usb_ifclk to clk).
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 usb_slwr  in  1  FPGA write strobe, active-high.
REQ-005 usb_slrd  in  1  FPGA read strobe, active-high.
REQ-006 usb_sloe  in  1  FPGA output-enable request, active-high.
REQ-007 usb_addr  in  2  endpoint select: 00=EP2 (OUT), 01=EP4 (OUT), 10=EP6 (IN), 11=EP8 (IN).
REQ-008 usb_data_in  in  8  byte written by FPGA.
REQ-009 usb_data_out  out  8  byte presented to FPGA.
REQ-010 usb_ep2_empty, usb_ep4_empty  out  1 each  OUT-endpoint empty flags.
REQ-011 usb_ep6_full, usb_ep8_full  out  1 each  IN-endpoint full flags.
REQ-012 host_out_valid, host_out_ep(1b: 0=EP2, 1=EP4), host_out_data(8b)  in; host_out_ready  out  host push into OUT endpoints.
REQ-013 host_in_sel(1b: 0=EP6, 1=EP8), host_in_ready  in; host_in_valid, host_in_data(8b)  out  host pop from IN endpoints.
REQ-014 err_clear  in  1; err_underflow, err_overflow, err_protocol  out  1 each  sticky error flags.

Function
REQ-015 Four independent circular FIFOs (EP2, EP4, EP6, EP8) of DEPTH bytes SHALL each hold rd pointer, wr pointer and AW+1-bit count.
REQ-016 All flags SHALL derive from registered counts: empty = (count==0), full = (count==DEPTH); acceptance decisions use pre-edge counts only.
REQ-017 usb_data_out SHALL equal head byte of EP selected by usb_addr when usb_sloe=1 and usb_addr[1]=0 (first-word fall-through, combinational from memory), else 8'h00; empty FIFO head SHALL read 8'h00.
REQ-018 FPGA read: usb_slrd=1, usb_slwr=0, usb_addr[1]=0, selected count>0 -> pop one byte at the edge; usb_sloe does not gate the pop.
REQ-019 FPGA write: usb_slwr=1, usb_slrd=0, usb_addr[1]=1, selected count<DEPTH -> store usb_data_in at the edge.
REQ-020 usb_slrd on empty OUT EP SHALL be ignored and set err_underflow; usb_slwr on full IN EP SHALL be ignored and set err_overflow.
REQ-021 usb_slrd with usb_addr[1]=1, usb_slwr with usb_addr[1]=0, or usb_slrd and usb_slwr together SHALL be ignored entirely and set err_protocol.
REQ-022 host_out_ready SHALL be 1 iff the EP selected by host_out_ep is not full; push occurs on host_out_valid && host_out_ready.
REQ-023 host_in_valid SHALL be 1 iff the EP selected by host_in_sel is not empty; host_in_data = its head byte (8'h00 if empty); pop on host_in_valid && host_in_ready.
REQ-024 Simultaneous host push and FPGA pop on the same OUT EP (or FPGA push and host pop on same IN EP) SHALL both occur when each is accepted per pre-edge count; count unchanged; push into a full FIFO is rejected even if a same-cycle pop occurs.
REQ-025 Pointers SHALL wrap modulo DEPTH; count never exceeds DEPTH nor underflows.
REQ-026 err_clear SHALL clear all error flags; an error event in the same cycle as err_clear SHALL win (flag set).
REQ-027 Latency: byte pushed at edge N SHALL be visible at the consumer (usb_data_out or host_in_data) and flag deasserted after edge N, i.e. in cycle N+1.

Reset
REQ-028 While reset=1 at an edge: all pointers and counts SHALL go to 0, error flags to 0; stored bytes are discarded; reset overrides any concurrent strobe or handshake.
REQ-029 After reset: usb_ep2_empty=usb_ep4_empty=1, usb_ep6_full=usb_ep8_full=0, host_out_ready=1, host_in_valid=0, usb_data_out=8'h00.

Verification
REQ-030 Host pushes 8'hA1,8'hA2 to EP2; FPGA sloe=1, addr=00, slrd 2 cycles -> usb_data_out A1 then A2, usb_ep2_empty=1 after second edge, no errors.
REQ-031 FPGA writes DEPTH bytes 0..15 to EP6 -> usb_ep6_full=1; 17th slwr -> ignored, err_overflow=1; host pops with sel=0 -> 0..15 in order.
REQ-032 slrd on empty EP4 -> err_underflow=1, pointers unchanged; err_clear -> flag 0 next cycle.
REQ-033 slrd with addr=10, then slrd+slwr together with addr=00 -> err_protocol=1, no count changes in either cycle.
REQ-034 EP2 full, host push and FPGA pop same cycle -> pop accepted, push rejected (host_out_ready=0), count DEPTH-1; wrap test with 3*DEPTH bytes streamed preserves order.
REQ-035 Reset asserted with EP8 holding 5 bytes and slwr active -> next cycle count 0, usb_ep8_full=0, host_in_valid=0 for sel=1.

Source files
------------

// File: rtl/fx2_fifo_responder.sv
// Behavioural responder for the FX2 slave-FIFO interface: two OUT endpoints (EP2/EP4) fed by
// the host and drained by the FPGA, two IN endpoints (EP6/EP8) filled by the FPGA and drained by the host.
module fx2_fifo_responder #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       usb_slwr,
  input  logic       usb_slrd,
  input  logic       usb_sloe,
  input  logic [1:0] usb_addr,
  input  logic [7:0] usb_data_in,
  output logic [7:0] usb_data_out,
  output logic       usb_ep2_empty,
  output logic       usb_ep4_empty,
  output logic       usb_ep6_full,
  output logic       usb_ep8_full,
  input  logic       host_out_valid,
  input  logic       host_out_ep,
  input  logic [7:0] host_out_data,
  output logic       host_out_ready,
  input  logic       host_in_sel,
  input  logic       host_in_ready,
  output logic       host_in_valid,
  output logic [7:0] host_in_data,
  input  logic       err_clear,
  output logic       err_underflow,
  output logic       err_overflow,
  output logic       err_protocol
);

  localparam int            NEP      = 4;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [NEP][DEPTH];
  logic [AW-1:0] rd_q  [NEP];
  logic [AW-1:0] rd_d  [NEP];
  logic [AW-1:0] wr_q  [NEP];
  logic [AW-1:0] wr_d  [NEP];
  logic [AW:0]   cnt_q [NEP];
  logic [AW:0]   cnt_d [NEP];
  logic [7:0]    head_s  [NEP];
  logic [7:0]    wdata_s [NEP];
  logic [NEP-1:0] empty_s, full_s, push_s, pop_s;
  logic [1:0]    out_idx_s, in_idx_s;
  logic          fpga_rd_s, fpga_wr_s, proto_s, uf_s, of_s, host_push_s, host_pop_s;
  logic          uf_q, uf_d, of_q, of_d, proto_q, proto_d;

  // Flags and fall-through head bytes come only from registered state.
  always_comb begin
    for (int i = 0; i < NEP; i++) begin
      empty_s[i] = (cnt_q[i] == '0);
      full_s[i]  = (cnt_q[i] == FULL_CNT);
      head_s[i]  = empty_s[i] ? 8'h00 : mem_q[i][rd_q[i]];
    end
  end

  // Strobe/handshake decode into per-endpoint push and pop enables.
  always_comb begin
    out_idx_s   = {1'b0, host_out_ep};
    in_idx_s    = {1'b1, host_in_sel};
    proto_s     = (usb_slrd && usb_slwr) || (usb_slrd && usb_addr[1]) || (usb_slwr && !usb_addr[1]);
    fpga_rd_s   = usb_slrd && !usb_slwr && !usb_addr[1];
    fpga_wr_s   = usb_slwr && !usb_slrd && usb_addr[1];
    uf_s        = fpga_rd_s && empty_s[usb_addr];
    of_s        = fpga_wr_s && full_s[usb_addr];
    host_push_s = host_out_valid && !full_s[out_idx_s];
    host_pop_s  = host_in_ready && !empty_s[in_idx_s];
    for (int i = 0; i < NEP; i++) begin
      push_s[i]  = (host_push_s && (out_idx_s == 2'(i))) ||
                   (fpga_wr_s && !full_s[i] && (usb_addr == 2'(i)));
      pop_s[i]   = (host_pop_s && (in_idx_s == 2'(i))) ||
                   (fpga_rd_s && !empty_s[i] && (usb_addr == 2'(i)));
      wdata_s[i] = (i < 2) ? host_out_data : usb_data_in;
    end
  end

  // Pointer/count next state; sticky errors let a same-cycle event beat err_clear.
  always_comb begin
    for (int i = 0; i < NEP; i++) begin
      rd_d[i] = pop_s[i]  ? rd_q[i] + AW'(1) : rd_q[i];
      wr_d[i] = push_s[i] ? wr_q[i] + AW'(1) : wr_q[i];
      case ({push_s[i], pop_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + (AW + 1)'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - (AW + 1)'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    uf_d    = uf_s    || (uf_q    && !err_clear);
    of_d    = of_s    || (of_q    && !err_clear);
    proto_d = proto_s || (proto_q && !err_clear);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NEP; i++) begin
        rd_q[i]  <= '0;
        wr_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      for (int i = 0; i < NEP; i++) begin
        rd_q[i]  <= rd_d[i];
        wr_q[i]  <= wr_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      uf_q    <= uf_d;
      of_q    <= of_d;
      proto_q <= proto_d;
    end
  end

  // Byte storage; contents need no reset because counts gate every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NEP; i++) begin
      if (push_s[i]) begin
        mem_q[i][wr_q[i]] <= wdata_s[i];
      end
    end
  end

  assign usb_data_out   = (usb_sloe && !usb_addr[1]) ? head_s[usb_addr] : 8'h00;
  assign usb_ep2_empty  = empty_s[0];
  assign usb_ep4_empty  = empty_s[1];
  assign usb_ep6_full   = full_s[2];
  assign usb_ep8_full   = full_s[3];
  assign host_out_ready = !full_s[out_idx_s];
  assign host_in_valid  = !empty_s[in_idx_s];
  assign host_in_data   = head_s[in_idx_s];
  assign err_underflow  = uf_q;
  assign err_overflow   = of_q;
  assign err_protocol   = proto_q;

endmodule

// File: tb/tb_fx2_fifo_responder.sv
// Directed bench for fx2_fifo_responder: host/FPGA transfers, flags, error flags, wrap and reset.
module tb_fx2_fifo_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       usb_slwr, usb_slrd, usb_sloe;
  logic [1:0] usb_addr;
  logic [7:0] usb_data_in, usb_data_out;
  logic       usb_ep2_empty, usb_ep4_empty, usb_ep6_full, usb_ep8_full;
  logic       host_out_valid, host_out_ep, host_out_ready;
  logic [7:0] host_out_data;
  logic       host_in_sel, host_in_ready, host_in_valid;
  logic [7:0] host_in_data;
  logic       err_clear, err_underflow, err_overflow, err_protocol;

  int n_cmp = 0;
  int n_err = 0;

  fx2_fifo_responder #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset),
    .usb_slwr(usb_slwr), .usb_slrd(usb_slrd), .usb_sloe(usb_sloe), .usb_addr(usb_addr),
    .usb_data_in(usb_data_in), .usb_data_out(usb_data_out),
    .usb_ep2_empty(usb_ep2_empty), .usb_ep4_empty(usb_ep4_empty),
    .usb_ep6_full(usb_ep6_full), .usb_ep8_full(usb_ep8_full),
    .host_out_valid(host_out_valid), .host_out_ep(host_out_ep),
    .host_out_data(host_out_data), .host_out_ready(host_out_ready),
    .host_in_sel(host_in_sel), .host_in_ready(host_in_ready),
    .host_in_valid(host_in_valid), .host_in_data(host_in_data),
    .err_clear(err_clear), .err_underflow(err_underflow),
    .err_overflow(err_overflow), .err_protocol(err_protocol)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; usb_slwr = 1'b0; usb_slrd = 1'b0; usb_sloe = 1'b1; usb_addr = 2'b00;
    usb_data_in = 8'h00; host_out_valid = 1'b0; host_out_ep = 1'b0; host_out_data = 8'h00;
    host_in_sel = 1'b0; host_in_ready = 1'b0; err_clear = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check_eq("rst_ep2_empty", 32'(usb_ep2_empty), 32'd1);
    check_eq("rst_ep4_empty", 32'(usb_ep4_empty), 32'd1);
    check_eq("rst_ep6_full", 32'(usb_ep6_full), 32'd0);
    check_eq("rst_ep8_full", 32'(usb_ep8_full), 32'd0);
    check_eq("rst_out_ready", 32'(host_out_ready), 32'd1);
    check_eq("rst_in_valid", 32'(host_in_valid), 32'd0);
    check_eq("rst_data_out", 32'(usb_data_out), 32'h00);
    check_eq("rst_errs", 32'({err_underflow, err_overflow, err_protocol}), 32'd0);

    // Host -> EP2 -> FPGA
    host_out_valid = 1'b1; host_out_ep = 1'b0; host_out_data = 8'hA1; tick();
    host_out_data = 8'hA2; tick();
    host_out_valid = 1'b0; #1;
    check_eq("ep2_head_a1", 32'(usb_data_out), 32'hA1);
    check_eq("ep2_not_empty", 32'(usb_ep2_empty), 32'd0);
    usb_slrd = 1'b1; tick();
    check_eq("ep2_head_a2", 32'(usb_data_out), 32'hA2);
    tick();
    usb_slrd = 1'b0; #1;
    check_eq("ep2_drained", 32'(usb_ep2_empty), 32'd1);
    check_eq("ep2_empty_data", 32'(usb_data_out), 32'h00);
    check_eq("ep2_no_err", 32'({err_underflow, err_overflow, err_protocol}), 32'd0);

    // FPGA fills EP6, overflows, host drains
    usb_addr = 2'b10; usb_slwr = 1'b1;
    for (int b = 0; b < 16; b++) begin
      usb_data_in = 8'(b); tick();
    end
    check_eq("ep6_full", 32'(usb_ep6_full), 32'd1);
    usb_data_in = 8'd16; tick();
    usb_slwr = 1'b0; #1;
    check_eq("ep6_overflow", 32'(err_overflow), 32'd1);
    check_eq("ep6_ovf_only", 32'({err_underflow, err_protocol}), 32'd0);
    host_in_sel = 1'b0; host_in_ready = 1'b1; #1;
    for (int k = 0; k < 16; k++) begin
      check_eq("ep6_pop", 32'({host_in_valid, host_in_data}), 32'({1'b1, 8'(k)}));
      tick();
    end
    host_in_ready = 1'b0; #1;
    check_eq("ep6_empty_after", 32'(host_in_valid), 32'd0);
    err_clear = 1'b1; tick();
    err_clear = 1'b0; #1;
    check_eq("ovf_cleared", 32'(err_overflow), 32'd0);

    // Underflow on EP4 with err_clear in the same cycle: error wins
    usb_addr = 2'b01; usb_slrd = 1'b1; err_clear = 1'b1; tick();
    usb_slrd = 1'b0; #1;
    check_eq("ep4_uf_wins", 32'(err_underflow), 32'd1);
    check_eq("ep4_still_empty", 32'(usb_ep4_empty), 32'd1);
    tick();
    err_clear = 1'b0; #1;
    check_eq("uf_cleared", 32'(err_underflow), 32'd0);
    host_out_valid = 1'b1; host_out_ep = 1'b1; host_out_data = 8'h55; tick();
    host_out_valid = 1'b0; #1;
    check_eq("ep4_head_55", 32'(usb_data_out), 32'h55);
    usb_slrd = 1'b1; tick();
    usb_slrd = 1'b0; #1;
    check_eq("ep4_drained", 32'(usb_ep4_empty), 32'd1);

    // Protocol errors leave counts alone
    host_out_valid = 1'b1; host_out_ep = 1'b0; host_out_data = 8'h77; tick();
    host_out_valid = 1'b0;
    usb_addr = 2'b10; usb_slrd = 1'b1; tick();
    usb_slrd = 1'b0; #1;
    check_eq("proto_rd_in", 32'(err_protocol), 32'd1);
    check_eq("proto_ep6_cnt", 32'({host_in_valid, usb_ep6_full}), 32'd0);
    err_clear = 1'b1; tick();
    err_clear = 1'b0;
    usb_addr = 2'b00; usb_slrd = 1'b1; usb_slwr = 1'b1; tick();
    usb_slrd = 1'b0; usb_slwr = 1'b0; #1;
    check_eq("proto_both", 32'(err_protocol), 32'd1);
    check_eq("proto_ep2_kept", 32'({usb_ep2_empty, usb_data_out}), 32'({1'b0, 8'h77}));
    err_clear = 1'b1; usb_slrd = 1'b1; tick();
    err_clear = 1'b0; usb_slrd = 1'b0; #1;
    check_eq("ep2_77_popped", 32'(usb_ep2_empty), 32'd1);

    // EP2 full: same-cycle push rejected, pop accepted
    host_out_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      host_out_data = 8'(8'h30 + k); tick();
    end
    check_eq("ep2_full_ready", 32'(host_out_ready), 32'd0);
    host_out_data = 8'hEE; usb_slrd = 1'b1; #1;
    check_eq("ep2_full_head", 32'(usb_data_out), 32'h30);
    tick();
    host_out_valid = 1'b0; usb_slrd = 1'b0; #1;
    check_eq("ep2_ready_after", 32'(host_out_ready), 32'd1);
    usb_slrd = 1'b1;
    for (int k = 1; k < 16; k++) begin
      check_eq("ep2_drain", 32'(usb_data_out), 32'(8'h30 + k));
      tick();
    end
    usb_slrd = 1'b0; #1;
    check_eq("ep2_no_ee", 32'({usb_ep2_empty, err_underflow}), 32'({1'b1, 1'b0}));

    // Stream 3*DEPTH bytes through EP8 with concurrent push/pop
    usb_addr = 2'b11; usb_slwr = 1'b1; host_in_sel = 1'b1; host_in_ready = 1'b1;
    for (int j = 0; j < 48; j++) begin
      usb_data_in = 8'(j); #1;
      if (j > 0) check_eq("ep8_stream", 32'({host_in_valid, host_in_data}), 32'({1'b1, 8'(j - 1)}));
      tick();
    end
    usb_slwr = 1'b0; #1;
    check_eq("ep8_last", 32'({host_in_valid, host_in_data}), 32'({1'b1, 8'd47}));
    tick();
    host_in_ready = 1'b0; #1;
    check_eq("ep8_empty", 32'(host_in_valid), 32'd0);

    // Reset with EP8 holding 5 bytes and slwr active
    usb_slwr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      usb_data_in = 8'(8'h90 + k); tick();
    end
    check_eq("ep8_five", 32'({host_in_valid, host_in_data}), 32'({1'b1, 8'h90}));
    reset = 1'b1; tick();
    reset = 1'b0; usb_slwr = 1'b0; #1;
    check_eq("rst_ep8_valid", 32'(host_in_valid), 32'd0);
    check_eq("rst_ep8_full", 32'(usb_ep8_full), 32'd0);
    check_eq("rst_ep8_data", 32'(host_in_data), 32'h00);
    check_eq("rst_out_ready2", 32'(host_out_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
